// File: rtl/servo_pkg.sv
// Shared constants, channel indices and FSM state type for the six-channel
// servo PWM generator.
package servo_pkg;

  localparam int NUM_CH = 6;

  localparam int CH_A1 = 0;
  localparam int CH_A2 = 1;
  localparam int CH_B1 = 2;
  localparam int CH_B2 = 3;
  localparam int CH_C1 = 4;
  localparam int CH_C2 = 5;

  // Default timing: 50 MHz clock, 20 ms frame, 500..2500 us pulse, 8 us per LSB.
  localparam int DEF_PRESC    = 50;
  localparam int DEF_FRAME_US = 20000;
  localparam int DEF_MIN_US   = 500;
  localparam int DEF_STEP_US  = 8;
  localparam int DEF_MAX_US   = 2500;

  typedef enum logic {IDLE, RUN} state_t;

endpackage

// File: rtl/servo_pwm_ch.sv
// One servo channel: angle pipe, stability-checked shadow, clamped width and
// registered output compare against the shared microsecond counter.
module servo_pwm_ch
  import servo_pkg::*;
#(
  parameter int MIN_US  = DEF_MIN_US,
  parameter int STEP_US = DEF_STEP_US,
  parameter int MAX_US  = DEF_MAX_US,
  parameter int UW      = 15
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [7:0]    i_angle,
  input  logic          i_load,
  input  state_t        i_state,
  input  logic [UW-1:0] i_us_cnt,
  output logic          o_pwm
);

  logic [7:0]    r_s1;
  logic [7:0]    r_s2;
  logic [7:0]    r_shadow;
  logic          r_pwm;
  logic [UW-1:0] w_raw;
  logic [UW-1:0] w_width;

  assign w_raw   = UW'(MIN_US) + UW'(r_shadow) * UW'(STEP_US);
  assign w_width = (w_raw > UW'(MAX_US)) ? UW'(MAX_US) : w_raw;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1     <= '0;
      r_s2     <= '0;
      r_shadow <= '0;
      r_pwm    <= 1'b0;
    end else begin
      r_s1 <= i_angle;
      r_s2 <= r_s1;
      // A word still settling across the two stages is ignored for this frame.
      if (i_load && (r_s1 == r_s2)) r_shadow <= r_s2;
      r_pwm <= (i_state == RUN) && (i_us_cnt < w_width);
    end
  end

  assign o_pwm = r_pwm;

endmodule

// File: rtl/servo_pwm6.sv
// Six-channel RC-servo PWM generator: run/stop FSM, tick prescaler and frame
// counter shared by six channel slices that update only at frame boundaries.
module servo_pwm6
  import servo_pkg::*;
#(
  parameter int PRESC    = DEF_PRESC,
  parameter int FRAME_US = DEF_FRAME_US,
  parameter int MIN_US   = DEF_MIN_US,
  parameter int STEP_US  = DEF_STEP_US,
  parameter int MAX_US   = DEF_MAX_US
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        angle_a1_i,
  input  logic [7:0]        angle_a2_i,
  input  logic [7:0]        angle_b1_i,
  input  logic [7:0]        angle_b2_i,
  input  logic [7:0]        angle_c1_i,
  input  logic [7:0]        angle_c2_i,
  input  logic              run_i,
  output logic [NUM_CH-1:0] pwm_o,
  output logic              frame_o,
  output logic              active_o
);

  localparam int UW = $clog2(FRAME_US + 1);
  localparam int PW = (PRESC > 1) ? $clog2(PRESC) : 1;

  logic          r_run_s1;
  logic          r_run_s2;
  state_t        r_state;
  state_t        w_state_nxt;
  logic [PW-1:0] r_presc;
  logic [UW-1:0] r_us_cnt;
  logic          r_frame;
  logic          w_tick;
  logic          w_wrap;
  logic          w_start;
  logic          w_load;
  logic [7:0]    w_angle [NUM_CH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_run_s1 <= 1'b0;
      r_run_s2 <= 1'b0;
    end else begin
      // NOTE: non-blocking, so the second flop captures the first flop's old value.
      r_run_s1 <= run_i;
      r_run_s2 <= r_run_s1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    // NOTE: every output gets a default first, so no path can infer a latch.
    w_state_nxt = r_state;
    w_tick      = (r_state == RUN) && (r_presc == PW'(PRESC - 1));
    w_wrap      = w_tick && (r_us_cnt == UW'(FRAME_US - 1));
    w_start     = 1'b0;
    case (r_state)
      IDLE: if (r_run_s2) begin
        w_state_nxt = RUN;
        w_start     = 1'b1;
      end
      RUN: if (w_wrap && !r_run_s2) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
    w_load = w_start || w_wrap;
  end

  // A stop request only takes effect at the wrap, so the last frame runs to completion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_presc  <= '0;
      r_us_cnt <= '0;
      r_frame  <= 1'b0;
    end else begin
      r_frame <= w_load && (w_state_nxt == RUN);
      if (w_start || (w_state_nxt == IDLE)) begin
        r_presc  <= '0;
        r_us_cnt <= '0;
      end else if (w_tick) begin
        r_presc  <= '0;
        r_us_cnt <= w_wrap ? '0 : r_us_cnt + 1'b1;
      end else begin
        r_presc <= r_presc + 1'b1;
      end
    end
  end

  assign frame_o  = r_frame;
  assign active_o = (r_state == RUN);

  assign w_angle[CH_A1] = angle_a1_i;
  assign w_angle[CH_A2] = angle_a2_i;
  assign w_angle[CH_B1] = angle_b1_i;
  assign w_angle[CH_B2] = angle_b2_i;
  assign w_angle[CH_C1] = angle_c1_i;
  assign w_angle[CH_C2] = angle_c2_i;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    servo_pwm_ch #(
      .MIN_US  (MIN_US),
      .STEP_US (STEP_US),
      .MAX_US  (MAX_US),
      .UW      (UW)
    ) u_ch (
      .clk      (clk),
      .rst_n    (rst_n),
      .i_angle  (w_angle[g]),
      .i_load   (w_load),
      .i_state  (r_state),
      .i_us_cnt (r_us_cnt),
      .o_pwm    (pwm_o[g])
    );
  end

endmodule
